// File: rtl/seg7_pkg.sv
// Shared segment encodings and BCD decode for the seven-segment scan driver.
// All patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment pattern plus its decimal point, as loaded into the output registers.
  typedef struct packed {
    logic       dp;
    logic [6:0] seg;
  } seg_out_t;

  localparam seg_out_t SEG_OFF = '{dp: 1'b1, seg: SEG_BLANK};

  // Non-BCD codes show a dash so a broken upstream counter is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero mask: bit i set when digit i and every higher digit are zero.
// Digit 0 is never masked so a zero value still shows "0".
module seg7_lz_mask #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [NUM_DIGITS-1:0][3:0] i_digits,
  output logic [NUM_DIGITS-1:0]      o_mask
);

  logic w_hz;

  always_comb begin
    o_mask = '0;
    w_hz   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_hz      = w_hz & (i_digits[i] == 4'd0);
      o_mask[i] = w_hz;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with shadowed BCD input,
// leading-zero blanking and an all-off guard at the start of every digit slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_V  = DIV_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  logic [DIV_W-1:0]            r_div;
  logic [IDX_W-1:0]            r_idx;
  logic [NUM_DIGITS-1:0][3:0]  r_dig;
  logic [NUM_DIGITS-1:0]       r_dp;
  logic [NUM_DIGITS-1:0]       r_an;
  seg_out_t                    r_out;

  logic                        w_wrap;
  logic [NUM_DIGITS-1:0]       w_mask;
  logic [NUM_DIGITS-1:0]       w_nxt_an;
  seg_out_t                    w_nxt_out;

  assign w_wrap = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
      r_idx <= '0;
    end else begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      if (w_wrap) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Shadow copy keeps a scan consistent while the upstream counters move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dig <= '0;
      r_dp  <= '0;
    end else if (load) begin
      r_dig <= digits;
      r_dp  <= dp_in;
    end
  end

  seg7_lz_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_mask (
    .i_digits(r_dig),
    .o_mask  (w_mask)
  );

  // Outputs follow the pre-edge div/idx, so the wrap edge still shows digit k
  // and the following edge lands in the guard of slot k+1.
  always_comb begin
    w_nxt_an  = '1;
    w_nxt_out = SEG_OFF;
    if (r_div >= GUARD_V) begin
      w_nxt_an      = ~(AN_ONE << r_idx);
      w_nxt_out.seg = (blank_lz && w_mask[r_idx]) ? SEG_BLANK : bcd_to_seg(r_dig[r_idx]);
      w_nxt_out.dp  = ~r_dp[r_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an  <= '1;
      r_out <= SEG_OFF;
    end else begin
      r_an  <= w_nxt_an;
      r_out <= w_nxt_out;
    end
  end

  assign an  = r_an;
  assign seg = r_out.seg;
  assign dp  = r_out.dp;

endmodule
